vend_controller: RTL and testbench

- Clocked sequencer for the vending-machine coin datapath.
- Edge-detects nickel/dime/quarter inputs and accumulates credit.
- When credit reaches PRICE, runs a dispense handshake with the product dispenser, then returns change (or a refund) as one nickel pulse at a time.
- Sits between the coin acceptor and the dispenser/change-hopper; its state and ret outputs feed the front-panel display.

---
 rtl/vend_controller.sv | 175 +++++++++++++++++
 tb/tb_vend_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Coin-path sequencer: edge-detects coins, accumulates credit, handshakes with
// the dispenser and pays change or refunds one nickel pulse at a time.
module vend_controller #(
  parameter int PRICE        = 25,
  parameter int CREDIT_W     = 6,
  parameter int DISP_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                cancel,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic                chg_nickel,
  output logic                coin_rej,
  output logic [2:0]          state,
  output logic [CREDIT_W-1:0] credit,
  output logic [3:0]          ret
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    DISPENSE = 3'd2,
    CHANGE   = 3'd3,
    REFUND   = 3'd4
  } state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(5);
  localparam logic [7:0]          TMO_LAST = 8'(DISP_TIMEOUT - 1);

  state_t              state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic [3:0]          ret_reg, ret_next;
  logic                disp_req_reg, disp_req_next;
  logic                chg_reg, chg_next;
  logic                rej_reg, rej_next;
  logic [7:0]          timer_reg, timer_next;
  logic [2:0]          coin_prev_reg;
  logic                cancel_prev_reg;

  logic [2:0]          coin_in, coin_ev;
  logic [CREDIT_W-1:0] coin_amt [3];
  logic [CREDIT_W-1:0] sum, credit_sum, remainder;
  logic                coin_any, cancel_ev;

  assign coin_in = {quarter, dime, nickel};

  // Bit 0 nickel, bit 1 dime, bit 2 quarter; each contributes its value on a rising edge.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_coin
      localparam logic [CREDIT_W-1:0] VAL = CREDIT_W'((gi == 0) ? 5 : (gi == 1) ? 10 : 25);
      assign coin_ev[gi]  = coin_in[gi] & ~coin_prev_reg[gi];
      assign coin_amt[gi] = coin_ev[gi] ? VAL : '0;
    end
  endgenerate

  assign sum        = coin_amt[0] + coin_amt[1] + coin_amt[2];
  assign coin_any   = |coin_ev;
  assign cancel_ev  = cancel & ~cancel_prev_reg;
  assign credit_sum = credit_reg + sum;
  assign remainder  = credit_reg - PRICE_C;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      credit_reg      <= '0;
      ret_reg         <= '0;
      disp_req_reg    <= 1'b0;
      chg_reg         <= 1'b0;
      rej_reg         <= 1'b0;
      timer_reg       <= '0;
      coin_prev_reg   <= '1;
      cancel_prev_reg <= 1'b1;
    end else begin
      state_reg       <= state_next;
      credit_reg      <= credit_next;
      ret_reg         <= ret_next;
      disp_req_reg    <= disp_req_next;
      chg_reg         <= chg_next;
      rej_reg         <= rej_next;
      timer_reg       <= timer_next;
      coin_prev_reg   <= coin_in;
      cancel_prev_reg <= cancel;
    end
  end

  always_comb begin
    state_next    = state_reg;
    credit_next   = credit_reg;
    ret_next      = ret_reg;
    disp_req_next = disp_req_reg;
    chg_next      = 1'b0;
    rej_next      = 1'b0;
    timer_next    = timer_reg;
    case (state_reg)
      IDLE: begin
        if (coin_any) begin
          ret_next    = '0;
          credit_next = sum;
          if (sum >= PRICE_C) begin
            state_next    = DISPENSE;
            disp_req_next = 1'b1;
            timer_next    = '0;
          end else begin
            state_next = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (coin_any) begin
          credit_next = credit_sum;
          if (credit_sum >= PRICE_C) begin
            state_next    = DISPENSE;
            disp_req_next = 1'b1;
            timer_next    = '0;
          end else if (cancel_ev) begin
            state_next = REFUND;
            chg_next   = 1'b1;
          end
        end else if (cancel_ev) begin
          state_next = REFUND;
          chg_next   = 1'b1;
        end
      end
      DISPENSE: begin
        rej_next = coin_any;
        if (disp_ack) begin
          disp_req_next = 1'b0;
          credit_next   = remainder;
          if (remainder != '0) begin
            state_next = CHANGE;
            chg_next   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else if (timer_reg == TMO_LAST) begin
          // Abort keeps the full credit so the refund returns everything.
          disp_req_next = 1'b0;
          state_next    = REFUND;
          chg_next      = 1'b1;
        end else begin
          timer_next = timer_reg + 8'd1;
        end
      end
      CHANGE, REFUND: begin
        rej_next = coin_any;
        if (chg_reg) begin
          credit_next = credit_reg - NICKEL_C;
          ret_next    = (ret_reg == 4'd15) ? 4'd15 : ret_reg + 4'd1;
        end else if (credit_reg == '0) begin
          state_next = IDLE;
        end else begin
          chg_next = 1'b1;
        end
      end
      default: begin
        state_next    = IDLE;
        credit_next   = '0;
        disp_req_next = 1'b0;
      end
    endcase
  end

  assign state      = state_reg;
  assign credit     = credit_reg;
  assign ret        = ret_reg;
  assign disp_req   = disp_req_reg;
  assign chg_nickel = chg_reg;
  assign coin_rej   = rej_reg;

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: each transaction queues its expected
// payout, and a negedge monitor pops and compares it when the FSM returns to IDLE.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst_n, nickel, dime, quarter, cancel, disp_ack;
  logic       disp_req, chg_nickel, coin_rej;
  logic [2:0] state;
  logic [5:0] credit;
  logic [3:0] ret;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ret;
    int pulses;
    int rej;
  } exp_t;
  exp_t sb[$];

  int   pulses = 0, rejs = 0, disp_cycles = 0, dbl = 0;
  logic chg_last = 1'b0;
  logic [2:0] prev_st = 3'd0;

  vend_controller #(.PRICE(25), .CREDIT_W(6), .DISP_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .nickel(nickel), .dime(dime), .quarter(quarter),
    .cancel(cancel), .disp_ack(disp_ack), .disp_req(disp_req),
    .chg_nickel(chg_nickel), .coin_rej(coin_rej), .state(state),
    .credit(credit), .ret(ret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Transaction monitor: accumulates payout activity until the FSM is back in IDLE.
  always @(negedge clk) begin
    exp_t e;
    if (state != 3'd0) begin
      if (chg_nickel) pulses++;
      if (chg_nickel && chg_last) dbl = 1;
      if (coin_rej) rejs++;
      if (state == 3'd2) disp_cycles++;
    end else begin
      if (prev_st != 3'd0) begin
        if (sb.size() == 0) begin
          check("sb_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          check("txn_ret", int'(ret), e.ret);
          check("txn_pulses", pulses, e.pulses);
          check("txn_rej", rejs, e.rej);
          check("txn_credit", int'(credit), 0);
          check("txn_alternate", dbl, 0);
          $display("txn done ret=%0d pulses=%0d rej=%0d", ret, pulses, rejs);
        end
      end
      pulses = 0; rejs = 0; disp_cycles = 0; dbl = 0;
    end
    chg_last = chg_nickel;
    prev_st  = state;
  end

  task automatic coin(input logic n, input logic d, input logic q, input logic c);
    nickel = n; dime = d; quarter = q; cancel = c;
    @(posedge clk); #1;
    nickel = 1'b0; dime = 1'b0; quarter = 1'b0; cancel = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic ack();
    disp_ack = 1'b1;
    @(posedge clk); #1;
    disp_ack = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && state != 3'd0; i++) begin
      @(posedge clk); #1;
    end
    check({tag, "_idle"}, int'(state), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; nickel = 1'b0; dime = 1'b0; quarter = 1'b1; cancel = 1'b0; disp_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", int'(state), 0);
    check("rst_credit", int'(credit), 0);
    check("rst_ret", int'(ret), 0);
    check("rst_disp_req", int'(disp_req), 0);
    check("rst_chg", int'(chg_nickel), 0);
    check("rst_rej", int'(coin_rej), 0);

    // Quarter held through reset release must not count.
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("hold_credit", int'(credit), 0);
    check("hold_state", int'(state), 0);
    quarter = 1'b0;
    @(posedge clk); #1;
    sb.push_back('{ret: 0, pulses: 0, rej: 0});
    coin(0, 0, 1, 0);
    check("hold_q_credit", int'(credit), 25);
    check("hold_q_state", int'(state), 2);
    ack();
    wait_idle("hold");

    // Exact price with nickels.
    sb.push_back('{ret: 0, pulses: 0, rej: 0});
    for (int i = 1; i <= 4; i++) begin
      coin(1, 0, 0, 0);
      check("exact_credit", int'(credit), 5 * i);
      check("exact_state", int'(state), 1);
    end
    coin(1, 0, 0, 0);
    check("exact_credit25", int'(credit), 25);
    check("exact_disp_state", int'(state), 2);
    check("exact_disp_req", int'(disp_req), 1);
    ack();
    check("exact_req_drop", int'(disp_req), 0);
    check("exact_idle", int'(state), 0);
    check("exact_zero", int'(credit), 0);
    check("exact_ret", int'(ret), 0);
    wait_idle("exact");

    // 45c buys the item and returns four nickels.
    sb.push_back('{ret: 4, pulses: 4, rej: 0});
    coin(0, 1, 0, 0);
    check("chg_d1", int'(credit), 10);
    coin(0, 1, 0, 0);
    check("chg_d2", int'(credit), 20);
    coin(0, 0, 1, 0);
    check("chg_q", int'(credit), 45);
    check("chg_disp", int'(state), 2);
    ack();
    check("chg_state", int'(state), 3);
    check("chg_remain", int'(credit), 20);
    wait_idle("change");

    // All three coins on the same edge add 40c.
    sb.push_back('{ret: 3, pulses: 3, rej: 0});
    coin(1, 1, 1, 0);
    check("sim_credit", int'(credit), 40);
    check("sim_state", int'(state), 2);
    ack();
    check("sim_remain", int'(credit), 15);
    wait_idle("simul");

    // Plain cancel at 15c.
    sb.push_back('{ret: 3, pulses: 3, rej: 0});
    coin(1, 0, 0, 0);
    coin(0, 1, 0, 0);
    check("can_credit", int'(credit), 15);
    check("can_collect", int'(state), 1);
    coin(0, 0, 0, 1);
    check("can_refund", int'(state), 4);
    wait_idle("cancel");

    // Nickel and cancel together at 15c: refund includes the nickel.
    sb.push_back('{ret: 4, pulses: 4, rej: 0});
    coin(1, 0, 0, 0);
    coin(0, 1, 0, 0);
    coin(1, 0, 0, 1);
    check("cancoin_refund", int'(state), 4);
    wait_idle("cancoin");

    // 30c with no ack: timeout to refund, busy dime rejected.
    sb.push_back('{ret: 6, pulses: 6, rej: 1});
    coin(1, 0, 0, 0);
    coin(0, 0, 1, 0);
    check("tmo_credit", int'(credit), 30);
    check("tmo_state", int'(state), 2);
    coin(0, 1, 0, 0);
    check("rej_credit", int'(credit), 30);
    check("rej_state", int'(state), 2);
    for (int i = 0; i < 100 && state == 3'd2; i++) begin
      @(posedge clk); #1;
    end
    check("tmo_refund", int'(state), 4);
    check("tmo_req", int'(disp_req), 0);
    check("tmo_cycles", disp_cycles, 15);
    wait_idle("timeout");

    repeat (3) @(posedge clk);
    #1;
    check("sb_left", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
